// File: rtl/ext_light_pkg.sv
// Shared definitions for the exterior-lighting controller.
//   MODE_*      : per-channel 2-bit mode codes carried on the Mode bus.
//   det_state_e : darkness detector state encoding.
package ext_light_pkg;

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_OFF  = 2'b01;
  localparam logic [1:0] MODE_ON   = 2'b10;
  localparam logic [1:0] MODE_DIM  = 2'b11;

  typedef enum logic {
    ST_BRIGHT = 1'b0,
    ST_DARK   = 1'b1
  } det_state_e;

endpackage

// File: rtl/dark_detector.sv
// Debounced darkness detector with hysteresis and persistence.
// A state change needs HOLD_CYC consecutive qualifying samples: below ON_TH to go dark,
// above OFF_TH to go bright. Readings in the band between the thresholds hold the state and
// restart the count.
// Ports:
//   CLK     in  clock, rising edge
//   Reset   in  synchronous active-high reset
//   Lum_sen in  unsigned luminosity sample, taken every cycle
//   Dark    out registered debounced darkness status
module dark_detector
  import ext_light_pkg::*;
#(
  parameter int unsigned LUM_W    = 8,
  parameter int unsigned ON_TH    = 40,
  parameter int unsigned OFF_TH   = 60,
  parameter int unsigned HOLD_CYC = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [LUM_W-1:0] Lum_sen,
  output logic             Dark
);

  localparam int unsigned CntW = $clog2(HOLD_CYC + 1);
  localparam logic [LUM_W-1:0] OnTh    = LUM_W'(ON_TH);
  localparam logic [LUM_W-1:0] OffTh   = LUM_W'(OFF_TH);
  localparam logic [CntW-1:0]  CntLast = CntW'(HOLD_CYC - 1);

  det_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            dark_q;
  logic            qual;

  // A sample qualifies when it argues for leaving the current state.
  assign qual = (state_q == ST_DARK) ? (Lum_sen > OffTh) : (Lum_sen < OnTh);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_BRIGHT;
      cnt_q   <= '0;
      dark_q  <= 1'b0;
    end else if (!qual) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      // This edge captures the HOLD_CYC-th consecutive qualifying sample.
      cnt_q <= '0;
      if (state_q == ST_BRIGHT) begin
        state_q <= ST_DARK;
        dark_q  <= 1'b1;
      end else begin
        state_q <= ST_BRIGHT;
        dark_q  <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign Dark = dark_q;

endmodule

// File: rtl/ext_light_ctrl_multi.sv
// Multi-channel exterior-lighting controller: one shared darkness detector, a free-running PWM
// counter and N_CH independently moded lamp outputs.
// Ports:
//   CLK       in  clock, rising edge
//   Reset     in  synchronous active-high reset
//   Lum_sen   in  luminosity sample
//   Mode      in  per-channel mode, channel i on Mode[2i+1:2i]
//   Duty      in  DIM duty shared by all channels
//   Ext_light out registered lamp drive, one bit per channel
//   Dark      out registered debounced darkness status
module ext_light_ctrl_multi
  import ext_light_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned LUM_W    = 8,
  parameter int unsigned ON_TH    = 40,
  parameter int unsigned OFF_TH   = 60,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned PWM_W    = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [LUM_W-1:0]  Lum_sen,
  input  logic [2*N_CH-1:0] Mode,
  input  logic [PWM_W-1:0]  Duty,
  output logic [N_CH-1:0]   Ext_light,
  output logic              Dark
);

  logic             dark;
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_on;

  dark_detector #(
    .LUM_W   (LUM_W),
    .ON_TH   (ON_TH),
    .OFF_TH  (OFF_TH),
    .HOLD_CYC(HOLD_CYC)
  ) u_dark_detector (
    .CLK    (CLK),
    .Reset  (Reset),
    .Lum_sen(Lum_sen),
    .Dark   (dark)
  );

  // Free-running; wraps naturally at 2^PWM_W.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt_q < Duty);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0] mode_ch;
    logic       light_d;
    logic       light_q;

    assign mode_ch = Mode[2*i +: 2];

    // Uses the registered Dark, so a Dark toggle reaches AUTO lamps one edge later.
    always_comb begin
      light_d = 1'b0;
      unique case (mode_ch)
        MODE_AUTO: light_d = dark;
        MODE_OFF:  light_d = 1'b0;
        MODE_ON:   light_d = 1'b1;
        MODE_DIM:  light_d = dark & pwm_on;
        default:   light_d = 1'b0;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (Reset) begin
        light_q <= 1'b0;
      end else begin
        light_q <= light_d;
      end
    end

    assign Ext_light[i] = light_q;
  end

  assign Dark = dark;

endmodule

// File: tb/tb_ext_light_ctrl_multi.sv
// Self-checking bench for ext_light_ctrl_multi: a table of directed vectors, hand-written
// corner sequences and a randomized phase, all compared against a behavioural model.
module tb_ext_light_ctrl_multi;

  localparam int N_CH     = 4;
  localparam int ON_TH    = 40;
  localparam int OFF_TH   = 60;
  localparam int HOLD_CYC = 4;
  localparam int PWM_P    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lum;
  logic [7:0] mode;
  logic [3:0] duty;
  logic [3:0] ext;
  logic       dark;

  always #5 clk = ~clk;

  ext_light_ctrl_multi #(
    .N_CH    (N_CH),
    .LUM_W   (8),
    .ON_TH   (ON_TH),
    .OFF_TH  (OFF_TH),
    .HOLD_CYC(HOLD_CYC),
    .PWM_W   (4)
  ) dut (
    .CLK      (clk),
    .Reset    (rst),
    .Lum_sen  (lum),
    .Mode     (mode),
    .Duty     (duty),
    .Ext_light(ext),
    .Dark     (dark)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: the state flips once the samples seen since the last flip end in a run
  // of HOLD_CYC samples that all argue for the other state.
  bit       m_dark = 1'b0;
  bit [3:0] m_light = 4'b0;
  int       m_cycles = 0;
  int       hist[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit argues_flip(input int l, input bit is_dark);
    return is_dark ? (l > OFF_TH) : (l < ON_TH);
  endfunction

  task automatic model_edge(input bit r, input int l, input logic [7:0] md, input int du);
    bit [3:0] nl;
    bit       all_q;
    if (r) begin
      m_dark   = 1'b0;
      m_light  = 4'b0;
      m_cycles = 0;
      hist.delete();
      return;
    end
    for (int i = 0; i < N_CH; i++) begin
      case (int'(md[2*i +: 2]))
        0:       nl[i] = m_dark;
        1:       nl[i] = 1'b0;
        2:       nl[i] = 1'b1;
        default: nl[i] = m_dark && ((m_cycles % PWM_P) < du);
      endcase
    end
    hist.push_back(l);
    if (hist.size() > HOLD_CYC) void'(hist.pop_front());
    if (hist.size() == HOLD_CYC) begin
      all_q = 1'b1;
      foreach (hist[k]) if (!argues_flip(hist[k], m_dark)) all_q = 1'b0;
      if (all_q) begin
        m_dark = !m_dark;
        hist.delete();
      end
    end
    m_cycles = m_cycles + 1;
    m_light  = nl;
  endtask

  // One clock edge: model follows the inputs present at the edge, then DUT is compared.
  task automatic step();
    bit         r  = rst;
    int         l  = int'(lum);
    logic [7:0] md = mode;
    int         du = int'(duty);
    @(posedge clk);
    model_edge(r, l, md, du);
    #1;
    chk("model_dark", int'(dark), int'(m_dark));
    chk("model_ext_light", int'(ext), int'(m_light));
  endtask

  task automatic run(input int l, input int n);
    lum = 8'(l);
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    bit       rst;
    int       lum;
    int       n;
    bit       exp_dark;
    bit [3:0] exp_light;
  } vec_t;

  vec_t vt[5];
  int   hi_cnt;

  initial begin
    rst  = 1'b1;
    lum  = 8'd90;
    mode = 8'h00;
    duty = 4'd0;

    // Reset, 20 bright cycles, then a dark step reaching Dark on edge 4 and lamps on edge 5.
    vt[0] = '{rst: 1'b1, lum: 90, n: 2,  exp_dark: 1'b0, exp_light: 4'b0000};
    vt[1] = '{rst: 1'b0, lum: 90, n: 20, exp_dark: 1'b0, exp_light: 4'b0000};
    vt[2] = '{rst: 1'b0, lum: 20, n: 3,  exp_dark: 1'b0, exp_light: 4'b0000};
    vt[3] = '{rst: 1'b0, lum: 20, n: 1,  exp_dark: 1'b1, exp_light: 4'b0000};
    vt[4] = '{rst: 1'b0, lum: 20, n: 3,  exp_dark: 1'b1, exp_light: 4'b1111};
    for (int v = 0; v < 5; v++) begin
      rst = vt[v].rst;
      lum = 8'(vt[v].lum);
      for (int k = 0; k < vt[v].n; k++) begin
        step();
        chk($sformatf("vec%0d_dark", v), int'(dark), int'(vt[v].exp_dark));
        chk($sformatf("vec%0d_ext_light", v), int'(ext), int'(vt[v].exp_light));
      end
    end

    // Return to bright, then a glitch in the dark run restarts the count.
    run(61, 5);
    chk("bright_again", int'(dark), 0);
    run(20, 3);
    run(50, 1);
    run(20, 3);
    chk("glitch_restarts_count", int'(dark), 0);
    run(20, 1);
    chk("dark_after_4_more", int'(dark), 1);
    run(20, 1);

    // Band and OFF_TH itself never release DARK; 61 does after 4 edges.
    run(50, 20);
    chk("band_holds_dark", int'(dark), 1);
    run(60, 10);
    chk("off_th_not_bright", int'(dark), 1);
    run(61, 3);
    chk("bright_not_yet", int'(dark), 1);
    run(61, 1);
    chk("bright_edge4", int'(dark), 0);
    chk("lamps_still_on", int'(ext), 4'b1111);
    run(61, 1);
    chk("lamps_off_next", int'(ext), 4'b0000);

    // ON_TH itself is not dark.
    run(40, 8);
    chk("on_th_not_dark", int'(dark), 0);

    // Mixed modes: ch3 DIM, ch2 FORCE_OFF, ch1 FORCE_ON, ch0 AUTO.
    mode = 8'b11_01_10_00;
    duty = 4'd4;
    run(90, 2);
    chk("mixed_bright", int'(ext), 4'b0010);
    run(20, 6);
    hi_cnt = 0;
    for (int k = 0; k < PWM_P; k++) begin
      step();
      if (ext[3]) hi_cnt++;
      chk("mixed_dark_low3", int'(ext[2:0]), 3'b011);
    end
    chk("dim_duty4_count", hi_cnt, 4);
    duty = 4'd15;
    step();
    hi_cnt = 0;
    for (int k = 0; k < PWM_P; k++) begin
      step();
      if (ext[3]) hi_cnt++;
    end
    chk("dim_duty15_count", hi_cnt, 15);
    duty = 4'd0;
    step();
    hi_cnt = 0;
    for (int k = 0; k < PWM_P; k++) begin
      step();
      if (ext[3]) hi_cnt++;
    end
    chk("dim_duty0_count", hi_cnt, 0);

    // Reset while DARK.
    mode = 8'h00;
    run(20, 2);
    rst = 1'b1;
    step();
    chk("rst_dark_clears", int'(dark), 0);
    chk("rst_light_clears", int'(ext), 0);
    rst = 1'b0;
    run(20, 3);
    chk("post_rst_not_yet", int'(dark), 0);
    run(20, 1);
    chk("post_rst_dark", int'(dark), 1);

    // Randomized phase: levels clustered around the thresholds, held for short runs.
    for (int seg = 0; seg < 800; seg++) begin
      int lv;
      case ($urandom_range(0, 9))
        0: lv = 20;
        1: lv = 39;
        2: lv = 40;
        3: lv = 41;
        4: lv = 50;
        5: lv = 59;
        6: lv = 60;
        7: lv = 61;
        8: lv = 90;
        default: lv = int'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 7) == 0) duty = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      lum = 8'(lv);
      step();
      rst = 1'b0;
      run(lv, int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
